// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline-control encodings and operand-match helper
package pipeline_pkg;
   typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} pipeState_t;
   typedef enum logic [1:0] {NONE = 2'b00, LU = 2'b01, BEX = 2'b10, BMEM = 2'b11} stallReason_t;
   localparam logic [4:0] REG_ZERO = 5'd0;
   function automatic logic srcMatch(input logic [4:0] r, input logic [4:0] rs, input logic [4:0] rt, input logic usesRt);
      return (r != REG_ZERO) && (r == rs || (usesRt && r == rt));
   endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear over increment
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);
   always_ff @(posedge clk or negedge reset)
      if (!reset) count <= '0;
      else if (clr) count <= '0;
      else if (inc && !(&count)) count <= count + W'(1);
endmodule

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: load-use/branch-operand stall and branch/jump flush control
module hazard_detection_unit
   import pipeline_pkg::*;
#(
   parameter int CNT_W     = 16,
   parameter int MAX_STALL = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       IF_ID_RegisterRs,
   input  logic [4:0]       IF_ID_RegisterRt,
   input  logic             IF_ID_UsesRt,
   input  logic             ID_Branch,
   input  logic             ID_BranchTaken,
   input  logic             ID_Jump,
   input  logic             ID_EX_MemRead,
   input  logic             ID_EX_RegWrite,
   input  logic [4:0]       ID_EX_RegisterRd,
   input  logic             EX_MEM_MemRead,
   input  logic [4:0]       EX_MEM_RegisterRd,
   input  logic             Counter_Clear,
   output logic             PC_Write,
   output logic             IF_ID_Write,
   output logic             ID_EX_Bubble,
   output logic             IF_ID_Flush,
   output logic [1:0]       Pipe_State,
   output logic [1:0]       Stall_Reason,
   output logic [CNT_W-1:0] Stall_Count,
   output logic [CNT_W-1:0] Flush_Count,
   output logic             Hazard_Error
);
   localparam int CW = $clog2(MAX_STALL + 1) + 1;
   localparam logic [CW-1:0] MAX_RUN = CW'(MAX_STALL);
   logic hzLu, hzBex, hzBmem, stall, exMatch;
   logic [CW-1:0] stallRun;
   pipeState_t state, nextState;
   stallReason_t reason, nextReason;
   assign exMatch = srcMatch(ID_EX_RegisterRd, IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_UsesRt);
   assign hzLu = ID_EX_MemRead && exMatch;
   assign hzBex = ID_Branch && ID_EX_RegWrite && exMatch;
   assign hzBmem = ID_Branch && EX_MEM_MemRead && srcMatch(EX_MEM_RegisterRd, IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_UsesRt);
   assign stall = hzLu | hzBex | hzBmem;
   assign PC_Write = !stall;
   assign IF_ID_Write = !stall;
   assign ID_EX_Bubble = stall;
   // a pending operand makes the comparator result meaningless, so stall wins
   assign IF_ID_Flush = !stall && (ID_Jump || (ID_Branch && ID_BranchTaken));
   assign Pipe_State = state;
   assign Stall_Reason = reason;
   always_comb begin
      nextState = stall ? STALL : IF_ID_Flush ? FLUSH : RUN;
      nextReason = hzBmem ? BMEM : hzBex ? BEX : hzLu ? LU : NONE;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= RUN;
         reason <= NONE;
         stallRun <= '0;
         Hazard_Error <= 1'b0;
      end else begin
         state <= nextState;
         reason <= nextReason;
         stallRun <= !stall ? '0 : stallRun >= MAX_RUN ? stallRun : stallRun + CW'(1);
         if (stall && stallRun >= MAX_RUN) Hazard_Error <= 1'b1;
      end
   sat_counter #(.W(CNT_W)) stallCounter (.clk(clk), .reset(reset), .clr(Counter_Clear), .inc(stall), .count(Stall_Count));
   sat_counter #(.W(CNT_W)) flushCounter (.clk(clk), .reset(reset), .clr(Counter_Clear), .inc(IF_ID_Flush), .count(Flush_Count));
endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb_hazard_detection_unit: directed vectors with queued expectations checked by a monitor
module tb_hazard_detection_unit;
   logic clk = 1'b0, reset = 1'b0;
   logic [4:0] rs = '0, rt = '0, exRd = '0, memRd = '0;
   logic usesRt = 0, branch = 0, taken = 0, jump = 0, exMemRead = 0, exRegWrite = 0, memMemRead = 0, clr = 0;
   logic pcWrite, ifIdWrite, bubble, flush, hazErr;
   logic [1:0] pipeState, stallReason;
   logic [3:0] stallCount, flushCount;
   int checks = 0, errors = 0;
   typedef struct {
      string n;
      logic s, f, err;
      logic [1:0] st, rsn;
      logic [3:0] sc, fc;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   hazard_detection_unit #(.CNT_W(4), .MAX_STALL(2)) dut (
      .clk(clk), .reset(reset),
      .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt), .IF_ID_UsesRt(usesRt),
      .ID_Branch(branch), .ID_BranchTaken(taken), .ID_Jump(jump),
      .ID_EX_MemRead(exMemRead), .ID_EX_RegWrite(exRegWrite), .ID_EX_RegisterRd(exRd),
      .EX_MEM_MemRead(memMemRead), .EX_MEM_RegisterRd(memRd), .Counter_Clear(clr),
      .PC_Write(pcWrite), .IF_ID_Write(ifIdWrite), .ID_EX_Bubble(bubble), .IF_ID_Flush(flush),
      .Pipe_State(pipeState), .Stall_Reason(stallReason), .Stall_Count(stallCount),
      .Flush_Count(flushCount), .Hazard_Error(hazErr)
   );

   task automatic chk(input string n, input string f, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s got %0h want %0h", n, f, act, exp);
      end
   endtask

   always @(negedge clk)
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk(e.n, "PC_Write", {3'b0, pcWrite}, {3'b0, !e.s});
         chk(e.n, "IF_ID_Write", {3'b0, ifIdWrite}, {3'b0, !e.s});
         chk(e.n, "ID_EX_Bubble", {3'b0, bubble}, {3'b0, e.s});
         chk(e.n, "IF_ID_Flush", {3'b0, flush}, {3'b0, e.f});
         chk(e.n, "Pipe_State", {2'b0, pipeState}, {2'b0, e.st});
         chk(e.n, "Stall_Reason", {2'b0, stallReason}, {2'b0, e.rsn});
         chk(e.n, "Stall_Count", stallCount, e.sc);
         chk(e.n, "Flush_Count", flushCount, e.fc);
         chk(e.n, "Hazard_Error", {3'b0, hazErr}, {3'b0, e.err});
      end

   // drives one cycle's inputs just after the edge and queues what the monitor must see before the next edge
   task automatic cyc(input string n, input logic [4:0] iRs, input logic [4:0] iRt, input logic iUt, input logic iBr,
                      input logic iTk, input logic iJp, input logic iEMr, input logic iERw, input logic [4:0] iERd,
                      input logic iMMr, input logic [4:0] iMRd, input logic iClr, input logic iRst,
                      input logic s, input logic f, input logic [1:0] st, input logic [1:0] rsn,
                      input logic [3:0] sc, input logic [3:0] fc, input logic err);
      exp_t e;
      @(posedge clk);
      #1;
      rs = iRs; rt = iRt; usesRt = iUt; branch = iBr; taken = iTk; jump = iJp;
      exMemRead = iEMr; exRegWrite = iERw; exRd = iERd; memMemRead = iMMr; memRd = iMRd; clr = iClr;
      reset = iRst;
      e.n = n; e.s = s; e.f = f; e.st = st; e.rsn = rsn; e.sc = sc; e.fc = fc; e.err = err;
      q.push_back(e);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      //   name       rs rt ut br tk jp eMr eRw eRd mMr mRd clr rst   s f st rsn sc fc err
      cyc("idle",     0, 0, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0,  1,    0, 0, 0, 0, 0, 0, 0);
      cyc("loadUse",  8, 0, 0, 0, 0, 0, 1,  0,  8,  0,  0,  0,  1,    1, 0, 0, 0, 0, 0, 0);
      cyc("luAfter",  0, 0, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0,  1,    0, 0, 1, 1, 1, 0, 0);
      cyc("ldBr1",    0, 9, 1, 1, 0, 0, 1,  1,  9,  0,  0,  0,  1,    1, 0, 0, 0, 1, 0, 0);
      cyc("ldBr2",    0, 9, 1, 1, 0, 0, 0,  0,  0,  1,  9,  0,  1,    1, 0, 1, 2, 2, 0, 0);
      cyc("ldBr3",    0, 9, 1, 1, 1, 0, 0,  0,  0,  0,  0,  0,  1,    0, 1, 1, 3, 3, 0, 0);
      cyc("ldBrDone", 0, 0, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0,  1,    0, 0, 2, 0, 3, 1, 0);
      cyc("zeroReg",  0, 0, 0, 0, 0, 0, 1,  0,  0,  0,  0,  0,  1,    0, 0, 0, 0, 3, 1, 0);
      cyc("luJump",   8, 0, 0, 0, 0, 1, 1,  0,  8,  0,  0,  0,  1,    1, 0, 0, 0, 3, 1, 0);
      cyc("jump",     0, 0, 0, 0, 0, 1, 0,  0,  0,  0,  0,  0,  1,    0, 1, 1, 1, 4, 1, 0);
      cyc("wd1",      8, 0, 0, 0, 0, 0, 1,  0,  8,  0,  0,  0,  1,    1, 0, 2, 0, 4, 2, 0);
      cyc("wd2",      8, 0, 0, 0, 0, 0, 1,  0,  8,  0,  0,  0,  1,    1, 0, 1, 1, 5, 2, 0);
      cyc("wd3",      8, 0, 0, 0, 0, 0, 1,  0,  8,  0,  0,  0,  1,    1, 0, 1, 1, 6, 2, 0);
      cyc("wd4",      8, 0, 0, 0, 0, 0, 1,  0,  8,  0,  0,  0,  1,    1, 0, 1, 1, 7, 2, 1);
      for (int k = 0; k < 8; k++)
         cyc("satRamp", 8, 0, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0, 1,   1, 0, 1, 1, 4'(8 + k), 2, 1);
      cyc("satHold",  8, 0, 0, 0, 0, 0, 1,  0,  8,  0,  0,  0,  1,    1, 0, 1, 1, 15, 2, 1);
      cyc("satHold2", 8, 0, 0, 0, 0, 0, 1,  0,  8,  0,  0,  0,  1,    1, 0, 1, 1, 15, 2, 1);
      cyc("clrStall", 8, 0, 0, 0, 0, 0, 1,  0,  8,  0,  0,  1,  1,    1, 0, 1, 1, 15, 2, 1);
      cyc("cleared",  0, 0, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0,  1,    0, 0, 1, 1, 0, 0, 1);
      cyc("errStick", 0, 0, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0,  1,    0, 0, 0, 0, 0, 0, 1);
      cyc("preRst",   8, 0, 0, 0, 0, 0, 1,  0,  8,  0,  0,  0,  1,    1, 0, 0, 0, 0, 0, 1);
      cyc("rstMid",   8, 0, 0, 0, 0, 0, 1,  0,  8,  0,  0,  0,  0,    1, 0, 0, 0, 0, 0, 0);
      cyc("rstHeld",  8, 0, 0, 0, 0, 0, 1,  0,  8,  0,  0,  0,  0,    1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1 reset = 1'b1;
      cyc("postRst",  0, 0, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0,  1,    0, 0, 1, 1, 1, 0, 0);
      repeat (3) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending %0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Stall/flush controller for the 5-stage MIPS pipeline.
- It handles the hazards that forwarding cannot resolve: load-use, and a branch in ID waiting on an operand still in EX or MEM. For these it freezes PC and IF/ID and inserts a bubble into ID/EX.
- On a taken branch or a jump it flushes IF/ID.
- It tracks a registered pipeline-control state, saturating stall and flush performance counters, and a sticky watchdog error for runaway stalls.

Parameters:
- CNT_W, 16, width of the performance counters.
- MAX_STALL, 2, consecutive stall cycles allowed before the error is raised. Load followed by a dependent branch is the legal worst case of 2.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- IF_ID_RegisterRs  input  5  rs of the instruction in ID.
- IF_ID_RegisterRt  input  5  rt of the instruction in ID.
- IF_ID_UsesRt  input  1  instruction in ID reads rt as a source.
- ID_Branch  input  1  beq/bne in ID.
- ID_BranchTaken  input  1  ID comparator result.
- ID_Jump  input  1  j/jal/jr in ID.
- ID_EX_MemRead  input  1  load in EX.
- ID_EX_RegWrite  input  1  EX instruction writes a register.
- ID_EX_RegisterRd  input  5  EX destination, already muxed.
- EX_MEM_MemRead  input  1  load in MEM.
- EX_MEM_RegisterRd  input  5  MEM destination.
- Counter_Clear  input  1  synchronous clear of both counters.
- PC_Write  output  1  PC enable.
- IF_ID_Write  output  1  IF/ID enable.
- ID_EX_Bubble  output  1  zero ID/EX control signals.
- IF_ID_Flush  output  1  replace IF/ID with NOP.
- Pipe_State  output  2  registered state: 00 RUN, 01 STALL, 10 FLUSH.
- Stall_Reason  output  2  registered reason: 00 none, 01 load-use, 10 branch-on-EX, 11 branch-on-MEM-load.
- Stall_Count  output  CNT_W  stall cycles, saturating.
- Flush_Count  output  CNT_W  flushes, saturating.
- Hazard_Error  output  1  sticky watchdog flag.

Behaviour:
- Source match: match(r) = (r != 0) && (r == IF_ID_RegisterRs || (IF_ID_UsesRt && r == IF_ID_RegisterRt)).
- Hazard terms, evaluated combinationally in the same cycle:
  - hz_lu = ID_EX_MemRead && match(ID_EX_RegisterRd).
  - hz_bex = ID_Branch && ID_EX_RegWrite && match(ID_EX_RegisterRd).
  - hz_bmem = ID_Branch && EX_MEM_MemRead && match(EX_MEM_RegisterRd).
- stall = hz_lu | hz_bex | hz_bmem.
- PC_Write = IF_ID_Write = !stall.
- ID_EX_Bubble = stall.
- IF_ID_Flush = !stall && (ID_Jump || (ID_Branch && ID_BranchTaken)).
- Stall has priority over flush, because the branch comparator result is invalid while an operand is pending.
- Stall_Reason priority is hz_bmem, then hz_bex, then hz_lu.
- A load followed by a dependent branch stalls 2 cycles: cycle 1 is hz_bex (rd match, RegWrite=1), cycle 2 is hz_bmem. Then IF_ID_Flush follows if the branch is taken.
- FSM, registered:
  - next = STALL if stall; FLUSH if IF_ID_Flush; otherwise RUN.
  - Pipe_State shows the previous cycle's decision (one-cycle latency).
  - Stall_Reason is registered alongside it, with 00 when not stalling.
- Consecutive-stall counter (internal, width clog2(MAX_STALL+1)+1):
  - increments while stall is asserted and resets to 0 when stall is deasserted.
  - when stall is asserted with the counter already at MAX_STALL, Hazard_Error is set.
  - Hazard_Error is cleared only by reset. Pipeline outputs are unaffected.
- Performance counters:
  - Stall_Count increments each stall cycle.
  - Flush_Count increments each IF_ID_Flush cycle.
  - Both saturate at all-ones.
  - Counter_Clear zeroes both on the next edge and has priority over increment.
- Reset (reset = 0), asynchronous:
  - Pipe_State = RUN, Stall_Reason = 00, counters = 0, Hazard_Error = 0, consecutive counter = 0.
  - Combinational outputs follow their inputs during reset, so a stall decision can still be made.
  - Reset asserted mid-stall drops the FSM to RUN immediately.
- Register $0 never causes a hazard.

Decomposition:
- Shared package `pipeline_pkg`:
  - state encodings RUN/STALL/FLUSH;
  - reason codes NONE/LU/BEX/BMEM;
  - REG_ZERO = 5'd0.
- One sub-module, `sat_counter` (parameter W; ports clk, reset, clr, inc, count). It is instantiated twice, for Stall_Count and Flush_Count.

Test Plan:
- Load-use:
  - Stimulus: ID_EX_MemRead=1, ID_EX_RegisterRd=8, IF_ID_RegisterRs=8.
  - Expect: PC_Write=0, ID_EX_Bubble=1; next cycle Pipe_State=01, Stall_Reason=01, Stall_Count=1.
- Load then dependent beq:
  - Stimulus: cycle 1 ID_EX_MemRead=1, ID_EX_RegWrite=1, Rd=9, Rt=9, UsesRt=1, Branch=1; cycle 2 EX_MEM_MemRead=1, EX_MEM_RegisterRd=9; cycle 3 BranchTaken=1.
  - Expect: stall for 2 cycles (reasons 10 then 11), then IF_ID_Flush=1; Stall_Count=2, Flush_Count=1, Hazard_Error=0.
- Writes to $0:
  - Stimulus: Rd=0 with MemRead=1 and Rs=0.
  - Expect: no stall; Pipe_State stays 00.
- Stall beats flush:
  - Stimulus: hz_lu condition together with ID_Jump=1.
  - Expect: IF_ID_Flush=0 and stall=1; Jump=1 with no hazard on the next cycle gives IF_ID_Flush=1.
- Watchdog:
  - Stimulus: hold the load-use condition for 3 cycles with MAX_STALL=2.
  - Expect: Hazard_Error=1 after the third edge, staying set until reset.
- Counters:
  - Stimulus: force Stall_Count to all-ones, then continue stalling; then pulse Counter_Clear during a stall.
  - Expect: the count holds at all-ones, and the clear gives 0 (clear beats increment).
- Async reset mid-stall:
  - Stimulus: drop reset between clock edges.
  - Expect: Pipe_State=00, counters=0, Hazard_Error=0 immediately, without waiting for an edge.
